// File: rtl/fp32_mat_pkg.sv
// rtl/fp32_mat_pkg.sv - shared widths, width helper and streamer FSM states for the fp32 matrix blocks
package fp32_mat_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FIN
  } stream_state_t;

  // Tag fields never collapse to zero width, so 1x1 matrices still elaborate.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp32_matrix_flat_streamer_if.sv
// rtl/fp32_matrix_flat_streamer_if.sv - tagged element stream between the flat-matrix streamer and its consumers
interface fp32_matrix_flat_streamer_if
  import fp32_mat_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int N  = ROWS * COLS;
  localparam int RW = safe_clog2(ROWS);
  localparam int CW = safe_clog2(COLS);
  localparam int IW = safe_clog2(N);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [RW-1:0]     m_r;
  logic [CW-1:0]     m_c;
  logic [IW-1:0]     m_idx;
  logic              m_last_col;
  logic              m_last;

  modport master (
    output m_valid, m_data, m_r, m_c, m_idx, m_last_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_r, m_c, m_idx, m_last_col, m_last,
    output m_ready
  );

endinterface

// File: rtl/fp32_mat_rc_counter.sv
// rtl/fp32_mat_rc_counter.sv - row/column/linear-index walker over a ROWS x COLS matrix
module fp32_mat_rc_counter
  import fp32_mat_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int N  = ROWS * COLS,
  localparam int RW = safe_clog2(ROWS),
  localparam int CW = safe_clog2(COLS),
  localparam int IW = safe_clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic [IW-1:0] idx,
  output logic          last_col,
  output logic          last
);
  localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);
  localparam logic [IW-1:0] I_MAX = IW'(N - 1);

  assign last_col = (c == C_MAX);
  assign last     = (idx == I_MAX);

  // Stepping past the final element wraps everything back to the origin.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r   <= '0;
      c   <= '0;
      idx <= '0;
    end else if (en) begin
      if (last) begin
        r   <= '0;
        c   <= '0;
        idx <= '0;
      end else begin
        idx <= idx + IW'(1);
        if (last_col) begin
          c <= '0;
          r <= r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fp32_matrix_flat_streamer.sv
// rtl/fp32_matrix_flat_streamer.sv - streams a row-major flat fp32 matrix one tagged element per beat
module fp32_matrix_flat_streamer
  import fp32_mat_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SNAPSHOT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DATA_W*ROWS*COLS-1:0] in_flat,
  output logic                        busy,
  output logic                        done,
  fp32_matrix_flat_streamer_if.master m
);
  localparam int N  = ROWS * COLS;
  localparam int FW = DATA_W * N;
  localparam int RW = safe_clog2(ROWS);
  localparam int CW = safe_clog2(COLS);
  localparam int IW = safe_clog2(N);

  stream_state_t     state;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [FW-1:0]     src_flat;
  logic [RW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_c;
  logic [IW-1:0]     cnt_idx;
  logic              cnt_last_col;
  logic              cnt_last;
  logic              accept;
  logic              fire;
  int                nxt_idx;

  assign accept = (state == ST_IDLE) && load;
  assign fire   = valid_q && m.m_ready;

  generate
    if (SNAPSHOT != 0) begin : g_snap
      logic [FW-1:0] snap_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          snap_q <= '0;
        end else if (accept) begin
          snap_q <= in_flat;
        end
      end
      assign src_flat = snap_q;
    end else begin : g_live
      assign src_flat = in_flat;
    end
  endgenerate

  fp32_mat_rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rc (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (fire),
    .r        (cnt_r),
    .c        (cnt_c),
    .idx      (cnt_idx),
    .last_col (cnt_last_col),
    .last     (cnt_last)
  );

  // Clamp on the final beat so the element select never leaves the bus.
  always_comb begin
    nxt_idx = 0;
    if (!cnt_last) begin
      nxt_idx = int'(cnt_idx) + 1;
    end
  end

  // Element 0 comes straight off in_flat because the snapshot only lands this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_STREAM;
            busy    <= 1'b1;
            valid_q <= 1'b1;
            data_q  <= in_flat[DATA_W-1:0];
          end
        end
        ST_STREAM: begin
          if (fire) begin
            if (cnt_last) begin
              state   <= ST_FIN;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              data_q <= src_flat[DATA_W*nxt_idx +: DATA_W];
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tags sit at zero outside a transfer, so gating the flags with valid keeps idle outputs clear.
  assign m.m_valid    = valid_q;
  assign m.m_data     = data_q;
  assign m.m_r        = cnt_r;
  assign m.m_c        = cnt_c;
  assign m.m_idx      = cnt_idx;
  assign m.m_last_col = valid_q && cnt_last_col;
  assign m.m_last     = valid_q && cnt_last;

endmodule

// File: tb/tb_fp32_matrix_flat_streamer.sv
// tb/tb_fp32_matrix_flat_streamer.sv - scoreboard bench for a 2x3 and a 1x1 streamer
module tb_fp32_matrix_flat_streamer;
  import fp32_mat_pkg::*;

  localparam int AN = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            a_load = 1'b0;
  logic            b_load = 1'b0;
  logic [32*AN-1:0] a_flat;
  logic [32*AN-1:0] a_orig;
  logic [31:0]     b_flat = 32'h0;
  logic            a_busy, a_done, b_busy, b_done;

  fp32_matrix_flat_streamer_if #(.ROWS(2), .COLS(3), .DATA_W(32)) a_if ();
  fp32_matrix_flat_streamer_if #(.ROWS(1), .COLS(1), .DATA_W(32)) b_if ();

  fp32_matrix_flat_streamer #(.ROWS(2), .COLS(3), .DATA_W(32), .SNAPSHOT(1)) dut_a (
    .clk (clk), .rst (rst), .load (a_load), .in_flat (a_flat),
    .busy (a_busy), .done (a_done), .m (a_if.master)
  );

  fp32_matrix_flat_streamer #(.ROWS(1), .COLS(1), .DATA_W(32), .SNAPSHOT(1)) dut_b (
    .clk (clk), .rst (rst), .load (b_load), .in_flat (b_flat),
    .busy (b_busy), .done (b_done), .m (b_if.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {data, r, c[1:0], idx[2:0], last_col, last}
  function automatic logic [39:0] pa(input logic [31:0] d, input logic r, input logic [1:0] c,
                                     input logic [2:0] idx, input logic lc, input logic l);
    return {d, r, c, idx, lc, l};
  endfunction

  logic [39:0] qa[$];
  logic [36:0] qb[$];

  task automatic push_a();
    for (int i = 0; i < AN; i++)
      qa.push_back(pa(32'h3F800000 + 32'(i), 1'(i / 3), 2'(i % 3), 3'(i), (i % 3) == 2, i == 5));
  endtask

  // Ready driver: mode 0 holds ready high, mode 1 repeats 1,0,0,1.
  int rmode = 0;
  initial begin
    int ph;
    ph = 0;
    a_if.m_ready = 1'b1;
    b_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) begin
        a_if.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        a_if.m_ready = 1'b1;
        ph = 0;
      end
    end
  end

  int          a_last_fire = -1;
  logic        a_stall_prev = 1'b0;
  logic [39:0] a_prev;

  initial begin
    logic [39:0] cur;
    logic [39:0] exp;
    forever begin
      @(negedge clk);
      cur = pa(a_if.m_data, a_if.m_r, a_if.m_c, a_if.m_idx, a_if.m_last_col, a_if.m_last);
      if (a_stall_prev) chk("a_stall_hold", {24'h0, cur}, {24'h0, a_prev});
      a_stall_prev = a_if.m_valid && !a_if.m_ready && !rst;
      a_prev = cur;
      if (a_if.m_valid && a_if.m_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat actual=%0h expected=none", cur);
        end else begin
          exp = qa.pop_front();
          chk("a_beat", {24'h0, cur}, {24'h0, exp});
          if (exp[0]) a_last_fire = cyc;
        end
      end
    end
  end

  initial begin
    logic [36:0] cur;
    forever begin
      @(negedge clk);
      cur = {b_if.m_data, b_if.m_r, b_if.m_c, b_if.m_idx, b_if.m_last_col, b_if.m_last};
      if (b_if.m_valid && b_if.m_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_beat actual=%0h expected=none", cur);
        end else begin
          chk("b_beat", {27'h0, cur}, {27'h0, qb.pop_front()});
        end
      end
    end
  end

  task automatic wait_done(input bit sel_b, input int bound, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sel_b ? b_done : a_done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_a(output int t0);
    @(posedge clk); #1;
    a_load = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d;
    logic seen;
    for (int i = 0; i < AN; i++) a_orig[32*i +: 32] = 32'h3F800000 + 32'(i);
    a_flat = a_orig;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(a_if.m_valid), 64'd0);
    chk("rst_a_busy_done", {62'h0, a_busy, a_done}, 64'd0);
    chk("rst_a_fields", 64'(pa(a_if.m_data, a_if.m_r, a_if.m_c, a_if.m_idx, a_if.m_last_col, a_if.m_last)), 64'd0);
    chk("rst_b_fields", {26'h0, b_if.m_valid, b_busy, b_done, b_if.m_data, b_if.m_last_col, b_if.m_last}, 64'd0);
    rst = 1'b0;

    // Full-rate pass
    push_a();
    load_a(t0);
    wait_done(1'b0, 50, d);
    chk("t1_done_latency", 64'(d - t0), 64'd7);
    chk("t1_busy_at_done", 64'(a_busy), 64'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 64'(a_done), 64'd0);
    chk("t1_all_beats", 64'(qa.size()), 64'd0);

    // Back-pressure pass
    rmode = 1;
    push_a();
    load_a(t0);
    wait_done(1'b0, 100, d);
    chk("t2_done_after_last_fire", 64'(d), 64'(a_last_fire + 1));
    chk("t2_all_beats", 64'(qa.size()), 64'd0);
    rmode = 0;

    // Source overwritten right after load
    push_a();
    @(posedge clk); #1;
    a_load = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a_load = 1'b0;
    a_flat = {AN{32'hDEADBEEF}};
    wait_done(1'b0, 50, d);
    chk("t3_done_latency", 64'(d - t0), 64'd7);
    chk("t3_all_beats", 64'(qa.size()), 64'd0);
    a_flat = a_orig;

    // Loads while busy and on the done cycle are dropped
    push_a();
    load_a(t0);
    @(posedge clk); #1;
    a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
    wait_done(1'b0, 50, d);
    chk("t4_done_latency", 64'(d - t0), 64'd7);
    a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
    @(negedge clk);
    chk("t4_done_load_ignored", {62'h0, a_if.m_valid, a_busy}, 64'd0);
    @(posedge clk); #1;
    push_a();
    a_load = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a_load = 1'b0;
    wait_done(1'b0, 50, d);
    chk("t4_restart_latency", 64'(d - t0), 64'd7);
    chk("t4_all_beats", 64'(qa.size()), 64'd0);

    // Reset mid-stream abandons the transfer
    for (int i = 0; i < 3; i++)
      qa.push_back(pa(32'h3F800000 + 32'(i), 1'b0, 2'(i), 3'(i), i == 2, 1'b0));
    load_a(t0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_valid_busy_done", {61'h0, a_if.m_valid, a_busy, a_done}, 64'd0);
    chk("t5_rst_tags", {58'h0, a_if.m_r, a_if.m_c, a_if.m_idx}, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | a_done | a_if.m_valid;
    end
    chk("t5_no_done_after_rst", 64'(seen), 64'd0);
    chk("t5_beats_consumed", 64'(qa.size()), 64'd0);

    // Single-element matrix
    b_flat = 32'h3F800000;
    qb.push_back({32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    b_load = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    b_load = 1'b0;
    wait_done(1'b1, 20, d);
    chk("t6_done_latency", 64'(d - t0), 64'd2);
    chk("t6_all_beats", 64'(qb.size()), 64'd0);
    @(negedge clk);
    chk("t6_idle_after", {62'h0, b_if.m_valid, b_done}, 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_matrix_flat_streamer.md
Name: fp32_matrix_flat_streamer

Overview:
- Reader side of the flattened-matrix bus that the fp32 exp matrix engine writes.
- On a load pulse, typically wired to the engine's done, it takes a ROWS×COLS fp32 matrix presented as a row-major flat bus.
- It emits the matrix one element per beat on a valid/ready stream, tagged with row, column and linear index plus last-of-row and last-of-matrix flags.
- Downstream consumers are the row-sum/normalise stages of attention scoring.

Parameters:
- ROWS, 4, matrix rows (≥1)
- COLS, 4, matrix columns (≥1)
- DATA_W, 32, element width in bits
- SNAPSHOT, 1, 1 = capture in_flat into an internal register on load; 0 = read in_flat live, which the source must hold stable while busy=1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle request to start streaming in_flat
- in_flat  in  DATA_W*ROWS*COLS  row-major matrix; element idx = r*COLS+c at bits [DATA_W*idx +: DATA_W]
- busy  out  1  high from the cycle after an accepted load through the final handshake
- done  out  1  one-cycle pulse after the final element is accepted
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  element value
- m_r  out  RW  row tag, RW = (ROWS<=1)?1:$clog2(ROWS)
- m_c  out  CW  column tag, CW = (COLS<=1)?1:$clog2(COLS)
- m_idx  out  IW  linear index, IW = (N<=1)?1:$clog2(N), N = ROWS*COLS
- m_last_col  out  1  beat is c==COLS-1
- m_last  out  1  beat is idx==N-1

Behaviour:
- Reset values: busy=0, done=0, m_valid=0. m_data, m_r, m_c, m_idx, m_last_col, m_last are all 0. State=IDLE.
- FSM states: IDLE, STREAM, FIN.
- IDLE: load=1 is accepted. If SNAPSHOT=1, in_flat is captured that cycle. Next cycle the FSM enters STREAM with busy=1, m_valid=1, element 0, tags (0,0,0). Latency from load to first valid is 1 cycle.
- STREAM, fire (m_valid&&m_ready):
  - If idx<N-1: advance to idx+1 next cycle. When c==COLS-1, c wraps to 0 and r increments. m_valid stays 1, giving 1 beat/cycle when m_ready is held high.
  - If idx==N-1: next cycle m_valid=0 and the FSM enters FIN.
- STREAM, no fire: m_valid and all m_* outputs hold bit-stable. No element is skipped or duplicated.
- FIN: done=1 for exactly one cycle and busy=0. The FSM then returns to IDLE.
- A load while busy, or in FIN, is ignored. There is no queueing.
- A load in the same cycle as done is also ignored. A new load is accepted only in IDLE.
- Output fields are registered. There is no combinational path from m_ready to m_valid or m_data.
- SNAPSHOT=0: element idx is sampled from in_flat at the cycle it is loaded into the output register.
- m_last_col and m_last derive only from the tags. For N=1, the single beat has both flags set.
- ROWS=1 and COLS=1 must elaborate, with 1-bit tag widths that stay 0.
- rst=1 at any point, including mid-stream or in FIN, forces reset values on the next edge. The partial transfer is abandoned and no done is emitted.
- Total cycles from load to done with m_ready held high: N+1.

Decomposition:
- Shared package fp32_mat_pkg: DATA_W default and the safe-clog2 width function used for RW/CW/IW. The same package is shared with fp32_exp_matrix_flat.
- One natural sub-module, fp32_mat_rc_counter: holds the r/c/idx counters with enable, wrap and last flags, reusable by the exp engine's sequencer.
- The element mux and snapshot register stay inline.

Test Plan:
- ROWS=2, COLS=3, SNAPSHOT=1, element i=0x3F800000+i, m_ready=1 -> 6 consecutive beats, data 0x3F800000..0x3F800005. Tags go (0,0)…(1,2). m_last_col is set on idx 2 and 5; m_last on idx 5. done pulses at cycle load+7.
- Same matrix with m_ready toggling 1,0,0,1,… -> outputs hold stable during stall cycles; exactly 6 fires in order; done follows the last fire by 1 cycle.
- SNAPSHOT=1: overwrite in_flat with 0xDEADBEEF one cycle after load -> streamed data is still the original 0x3F80000x values.
- Load pulsed again at the 3rd beat, and on the done cycle -> both ignored. A load 2 cycles after done restarts at idx 0.
- rst asserted after the 2nd fire -> next cycle m_valid=0, busy=0, tags 0, and no done pulse.
- ROWS=1, COLS=1, element 0x3F800000 -> a single beat with m_last=m_last_col=1, then a done pulse.
